comp: RTL and testbench

COMP -- requirements
Module: comp

---
 rtl/comp.sv | 57 +++++
 tb/tb_comp.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/comp.sv
// Registered magnitude comparator: gt/eq/lt of a versus b, one-cycle latency.
// Operands are unsigned or two's-complement depending on SIGNED.
module comp #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    logic gt_d, eq_d, lt_d;
    logic gt_q, eq_q, lt_q;
    logic decided;

    // Scan MSB to LSB; the first differing bit decides. In signed mode the
    // sign bit carries negative weight, so its sense is swapped.
    always_comb begin
        gt_d    = 1'b0;
        lt_d    = 1'b0;
        decided = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!decided && (a[i] != b[i])) begin
                decided = 1'b1;
                if (SIGNED && (i == WIDTH - 1)) begin
                    gt_d = b[i];
                    lt_d = a[i];
                end else begin
                    gt_d = a[i];
                    lt_d = b[i];
                end
            end
        end
        eq_d = (a == b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q <= 1'b0;
            eq_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            gt_q <= gt_d;
            eq_q <= eq_d;
            lt_q <= lt_d;
        end
    end

    assign gt = gt_q;
    assign eq = eq_q;
    assign lt = lt_q;

endmodule

// File: tb/tb_comp.sv
// Self-checking bench for comp: directed 4-bit vectors, async reset sequence,
// and a random sweep over WIDTH 1/4/16 in both signed modes.
module tb_comp;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;
    localparam logic [2:0] R_0  = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [5:0]  gt_v, eq_v, lt_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // instance k: 0/1 -> WIDTH 4, 2/3 -> WIDTH 1, 4/5 -> WIDTH 16; odd k signed
    comp #(.WIDTH(4),  .SIGNED(1'b0)) u_u4  (.clk(clk), .rst_n(rst_n), .a(a4),  .b(b4),  .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]));
    comp #(.WIDTH(4),  .SIGNED(1'b1)) u_s4  (.clk(clk), .rst_n(rst_n), .a(a4),  .b(b4),  .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]));
    comp #(.WIDTH(1),  .SIGNED(1'b0)) u_u1  (.clk(clk), .rst_n(rst_n), .a(a1),  .b(b1),  .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2]));
    comp #(.WIDTH(1),  .SIGNED(1'b1)) u_s1  (.clk(clk), .rst_n(rst_n), .a(a1),  .b(b1),  .gt(gt_v[3]), .eq(eq_v[3]), .lt(lt_v[3]));
    comp #(.WIDTH(16), .SIGNED(1'b0)) u_u16 (.clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .gt(gt_v[4]), .eq(eq_v[4]), .lt(lt_v[4]));
    comp #(.WIDTH(16), .SIGNED(1'b1)) u_s16 (.clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .gt(gt_v[5]), .eq(eq_v[5]), .lt(lt_v[5]));

    function automatic logic [2:0] res(int k);
        return {gt_v[k], eq_v[k], lt_v[k]};
    endfunction

    function automatic int inst_w(int k);
        return (k < 2) ? 4 : (k < 4) ? 1 : 16;
    endfunction

    // Reference compare through 64-bit integer arithmetic
    function automatic logic [2:0] ref_cmp(logic [63:0] a, logic [63:0] b, int w, bit s);
        longint      sa, sb;
        logic [63:0] ua, ub;
        ua = (a << (64 - w)) >> (64 - w);
        ub = (b << (64 - w)) >> (64 - w);
        sa = $signed(a << (64 - w)) >>> (64 - w);
        sb = $signed(b << (64 - w)) >>> (64 - w);
        if (ua == ub) return R_EQ;
        if (s) return (sa > sb) ? R_GT : R_LT;
        return (ua > ub) ? R_GT : R_LT;
    endfunction

    function automatic logic [63:0] inst_a(int k);
        return (k < 2) ? {60'd0, a4} : (k < 4) ? {63'd0, a1} : {48'd0, a16};
    endfunction

    function automatic logic [63:0] inst_b(int k);
        return (k < 2) ? {60'd0, b4} : (k < 4) ? {63'd0, b1} : {48'd0, b16};
    endfunction

    task automatic check(string name, int k, logic [2:0] exp);
        logic [2:0] act;
        act = res(k);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got {gt,eq,lt}=%b, expected %b", name, k, act, exp);
        end else begin
            $display("ok   %s inst%0d: {gt,eq,lt}=%b", name, k, act);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] exp_u;
        logic [2:0] exp_s;
    } vec_t;

    vec_t vecs [10];
    logic [2:0] prev_u, prev_s;
    logic [2:0] exp_r [6];

    initial begin
        vecs[0] = '{4'b1010, 4'b1111, R_LT, R_LT};
        vecs[1] = '{4'b1010, 4'b1010, R_EQ, R_EQ};
        vecs[2] = '{4'b1010, 4'b0000, R_GT, R_LT};
        vecs[3] = '{4'b0111, 4'b1000, R_LT, R_GT};
        vecs[4] = '{4'b0000, 4'b0000, R_EQ, R_EQ};
        vecs[5] = '{4'b1111, 4'b0000, R_GT, R_LT};
        vecs[6] = '{4'b0001, 4'b0010, R_LT, R_LT};
        vecs[7] = '{4'b1000, 4'b1111, R_LT, R_LT};
        vecs[8] = '{4'b0110, 4'b0101, R_GT, R_GT};
        vecs[9] = '{4'b1110, 4'b1101, R_GT, R_GT};

        // Power-on reset: outputs forced low
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) check("por_zero", k, R_0);
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) check("por_hold", k, R_0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) check("first_edge_eq", k, R_EQ);

        // Directed 4-bit vectors; also confirm outputs hold between edges
        prev_u = R_EQ;
        prev_s = R_EQ;
        for (int i = 0; i < 10; i++) begin
            a4 = vecs[i].a;
            b4 = vecs[i].b;
            #1;
            check("hold_between_edges_u", 0, prev_u);
            check("hold_between_edges_s", 1, prev_s);
            @(posedge clk); #1;
            check($sformatf("vec%0d_u a=%b b=%b", i, vecs[i].a, vecs[i].b), 0, vecs[i].exp_u);
            check($sformatf("vec%0d_s a=%b b=%b", i, vecs[i].a, vecs[i].b), 1, vecs[i].exp_s);
            prev_u = vecs[i].exp_u;
            prev_s = vecs[i].exp_s;
        end

        // Async reset mid-stream while gt=1
        a4 = 4'b1010;
        b4 = 4'b0000;
        @(posedge clk); #1;
        check("pre_reset_gt", 0, R_GT);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) check("async_reset_zero", k, R_0);
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) check("reset_held_zero", k, R_0);
        a4 = '0; b4 = '0; a1 = '0; b1 = '0; a16 = '0; b16 = '0;
        #2 rst_n = 1'b1;
        #1;
        check("release_no_edge", 0, R_0);
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) check("release_first_edge_eq", k, R_EQ);

        // Random sweep, 1-cycle latency against the reference
        for (int k = 0; k < 6; k++) exp_r[k] = R_EQ;
        for (int c = 0; c < 150; c++) begin
            a4  = 4'($urandom);
            b4  = (c % 7 == 0) ? a4 : 4'($urandom);
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            a16 = 16'($urandom);
            b16 = (c % 9 == 0) ? a16 : 16'($urandom);
            for (int k = 0; k < 6; k++)
                exp_r[k] = ref_cmp(inst_a(k), inst_b(k), inst_w(k), (k % 2) == 1);
            @(posedge clk); #1;
            for (int k = 0; k < 6; k++) begin
                check($sformatf("rand c%0d a=%0h b=%0h", c, inst_a(k), inst_b(k)), k, exp_r[k]);
                n_tests++;
                if (!$onehot(res(k))) begin
                    n_fail++;
                    $display("FAIL onehot c%0d inst%0d: got %b, required exactly one bit set", c, k, res(k));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
